// File: rtl/counter_cmd_ctrl_pkg.sv
// Shared types for the counter command sequencer: command opcodes and FSM states.
package counter_cmd_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_LOAD   = 2'b01,
      OP_STEP   = 2'b10,
      OP_RUN_TO = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LD   = 3'd1,
      ST_STEP = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/counter_cmd_ctrl.sv
// Command sequencer in front of the lab counter: accepts LOAD/STEP/RUN_TO
// commands and drives the counter's load/enable/data, pulsing done on completion.
module counter_cmd_ctrl
   import counter_cmd_ctrl_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_arg,
   input  logic             hold,
   input  logic             abort,
   input  logic [WIDTH-1:0] count,
   output logic             load,
   output logic             enable,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_r;
   state_e           next_s;
   logic [WIDTH-1:0] arg_r;
   logic [WIDTH-1:0] remain_r;
   logic             accept_s;
   cmd_op_e          op_s;

   assign op_s     = cmd_op_e'(cmd_op);
   assign accept_s = cmd_valid && (state_r == ST_IDLE);
   assign data     = arg_r;

   // State register, latched argument and the STEP down-counter.
   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_r  <= ST_IDLE;
         arg_r    <= '0;
         remain_r <= '0;
      end else begin
         state_r <= next_s;
         if (accept_s) begin
            arg_r <= cmd_arg;
            if (op_s == OP_STEP) begin
               remain_r <= cmd_arg;
            end else begin
               remain_r <= remain_r;
            end
         end else if ((state_r == ST_STEP) && enable) begin
            remain_r <= remain_r - ONE;
         end else begin
            remain_r <= remain_r;
         end
      end
   end

   // Next-state and output decode; enable additionally looks at count/hold/abort.
   always_comb begin
      next_s    = state_r;
      load      = 1'b0;
      enable    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      cmd_ready = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy      = 1'b0;
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (op_s)
                  OP_NOP:    next_s = ST_DONE;
                  OP_LOAD:   next_s = ST_LD;
                  OP_STEP:   next_s = (cmd_arg == '0) ? ST_DONE : ST_STEP;
                  OP_RUN_TO: next_s = ST_RUN;
                  default:   next_s = ST_IDLE;
               endcase
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_LD: begin
            load   = 1'b1;
            next_s = ST_DONE;
         end
         ST_STEP: begin
            if (abort) begin
               next_s = ST_IDLE;
            end else if (!hold) begin
               enable = 1'b1;
               next_s = (remain_r == ONE) ? ST_DONE : ST_STEP;
            end else begin
               next_s = ST_STEP;
            end
         end
         ST_RUN: begin
            // count is registered, so stopping on equality never overshoots
            if (abort) begin
               next_s = ST_IDLE;
            end else if (count == arg_r) begin
               next_s = ST_DONE;
            end else begin
               enable = !hold;
               next_s = ST_RUN;
            end
         end
         ST_DONE: begin
            done   = 1'b1;
            next_s = ST_IDLE;
         end
         default: begin
            busy   = 1'b0;
            next_s = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Self-checking bench: sequencer driving a behavioural counter, checked against
// a per-command outcome model (final count, enable/load cycles, latency).
module tb_counter_cmd_ctrl;
   import counter_cmd_ctrl_pkg::*;

   localparam int W   = 5;
   localparam int MOD = 32;

   logic         clk = 1'b0;
   logic         rst_;
   logic         cmd_valid, cmd_ready, hold, abort;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_arg, count, data;
   logic         load, enable, busy, done;

   int errors = 0;
   int checks = 0;
   int model_count = 0;

   always #5 clk = ~clk;

   counter_cmd_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .hold(hold), .abort(abort),
      .count(count), .load(load), .enable(enable), .data(data),
      .busy(busy), .done(done)
   );

   // Lab counter: load wins over enable, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_)       count <= '0;
      else if (load)   count <= data;
      else if (enable) count <= count + 5'd1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one command and compare its whole-command outcome with the model.
   task automatic run_cmd(input logic [1:0] op, input int arg,
                          input logic [63:0] mask, input string tag);
      int exp_en, exp_ld, exp_lat, exp_count;
      int en_n, ld_n, done_cyc, start;
      en_n = 0; ld_n = 0; done_cyc = 0;
      start = model_count;
      case (op)
         2'b00:   begin exp_en = 0;   exp_ld = 0; exp_lat = 1;       exp_count = start; end
         2'b01:   begin exp_en = 0;   exp_ld = 1; exp_lat = 2;       exp_count = arg; end
         2'b10:   begin exp_en = arg; exp_ld = 0; exp_lat = arg + 1; exp_count = (start + arg) % MOD; end
         default: begin
            exp_en = (arg - start + MOD) % MOD;
            exp_ld = 0; exp_lat = exp_en + 2; exp_count = arg;
         end
      endcase
      check({tag, "_ready_before"}, int'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = W'(arg);
      cycle();
      cmd_valid = 1'b0; cmd_op = 2'b00;
      for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
         hold = (cyc < 64) ? mask[cyc] : 1'b0;
         #1;
         if (enable) en_n++;
         if (load) begin
            ld_n++;
            check({tag, "_data"}, int'(data), arg);
         end
         if (hold) check({tag, "_hold_gate"}, int'(enable), 0);
         check({tag, "_ld_en_excl"}, int'(load & enable), 0);
         check({tag, "_busy"}, int'(busy && !cmd_ready), 1);
         if (done) done_cyc = cyc;
         cycle();
      end
      hold = 1'b0;
      check({tag, "_done_seen"}, int'(done_cyc != 0), 1);
      if (mask == 64'd0) check({tag, "_latency"}, done_cyc, exp_lat);
      check({tag, "_enables"}, en_n, exp_en);
      check({tag, "_loads"}, ld_n, exp_ld);
      check({tag, "_count"}, int'(count), exp_count);
      check({tag, "_done_single"}, int'(done), 0);
      check({tag, "_ready_after"}, int'(cmd_ready && !busy), 1);
      model_count = exp_count;
   endtask

   initial begin
      logic [63:0] mask;
      int start;
      rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0;
      hold = 1'b0; abort = 1'b0;
      repeat (3) cycle();
      check("rst_outputs", int'({load, enable, busy, done}), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_data", int'(data), 0);
      rst_ = 1'b1;
      cycle();

      run_cmd(2'b01, 7, 64'd0, "load7");
      run_cmd(2'b10, 3, 64'd0, "step3");
      mask = 64'd0; mask[2] = 1'b1; mask[3] = 1'b1;
      run_cmd(2'b11, 14, mask, "run14_hold");
      run_cmd(2'b01, 30, 64'd0, "load30");
      run_cmd(2'b11, 2, 64'd0, "run_wrap");
      run_cmd(2'b10, 0, 64'd0, "step0");
      run_cmd(2'b11, 2, 64'd0, "run_equal");
      run_cmd(2'b00, 9, 64'd0, "nop");
      abort = 1'b1;
      run_cmd(2'b01, 5, 64'd0, "load_abort_ignored");
      abort = 1'b0;

      // abort STEP 5 after two enabled cycles
      start = model_count;
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_arg = 5'd5;
      cycle();
      cmd_valid = 1'b0;
      check("abort_en1", int'(enable), 1);
      cycle();
      check("abort_en2", int'(enable), 1);
      cycle();
      abort = 1'b1;
      #1;
      check("abort_en_low", int'(enable), 0);
      check("abort_no_done", int'(done), 0);
      cycle();
      abort = 1'b0;
      check("abort_idle", int'(cmd_ready && !busy), 1);
      check("abort_no_done2", int'(done), 0);
      check("abort_count", int'(count), (start + 2) % MOD);
      model_count = (start + 2) % MOD;

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 0) mask = 64'd0;
         else mask = {$urandom(), $urandom()} & {$urandom(), $urandom()};
         run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)),
                 mask, $sformatf("rnd%0d", i));
      end

      // reset in the middle of a RUN_TO
      start = model_count;
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_arg = W'((start + 20) % MOD);
      cycle();
      cmd_valid = 1'b0;
      repeat (3) cycle();
      check("midrun_busy", int'(busy), 1);
      rst_ = 1'b0;
      cycle();
      check("midrun_rst_outputs", int'({load, enable, busy, done}), 0);
      check("midrun_rst_ready", int'(cmd_ready), 1);
      check("midrun_rst_data", int'(data), 0);
      rst_ = 1'b1;
      cycle();
      check("midrun_no_done", int'(done), 0);
      model_count = 0;
      run_cmd(2'b10, 4, 64'd0, "post_rst_step");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
